// File: rtl/sm83_pkg.sv
// Shared SM83 core types and constants used by the front-end stages.
package sm83_pkg;

  typedef logic [7:0] instr_t;

  // First byte of every two-byte (CB-prefixed) opcode.
  localparam instr_t OP_INSTR_16 = 8'hCB;

  typedef enum logic {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  localparam int FETCH_Q_DEPTH = 2;

  typedef struct packed {
    instr_t      instr;
    logic [15:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO holding fetched bytes with their addresses.
module fetch_queue
  import sm83_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);

  fetch_entry_t slots [FETCH_Q_DEPTH];
  logic         rd_ptr;
  logic         wr_ptr;
  logic         do_push;
  logic         do_pop;

  assign full    = (count == 2'(FETCH_Q_DEPTH));
  assign empty   = (count == 2'd0);
  assign do_pop  = pop & !empty;
  // A pop frees the slot, so a push into a full queue is legal in the same cycle.
  assign do_push = push & (!full | do_pop);
  assign head    = slots[rd_ptr];

  // Pointers and occupancy; flush empties the queue without touching storage.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      if (do_push && !do_pop)      count <= count + 2'd1;
      else if (do_pop && !do_push) count <= count - 2'd1;
    end
  end

  // Entry storage; contents are only meaningful while counted as occupied.
  always_ff @(posedge clk) begin
    if (do_push && !flush) slots[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch.sv
// Instruction-byte fetch stage: owns the fetch PC, issues byte reads and
// buffers returned bytes for decode, tracking the CB prefix.
module fetch
  import sm83_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        o_valid,
  input  logic        i_ready,
  input  logic        i_opcode,
  output instr_t      o_instr,
  output logic [15:0] o_pc,
  output logic        o_is_instr16,
  input  logic        i_redirect,
  input  logic [15:0] i_redirect_pc,
  input  logic        i_halt,
  input  logic        i_wake
);

  fetch_state_t state_q, state_d;
  logic [15:0]  fpc;
  logic [15:0]  disc_addr;
  logic         pend;
  logic         discard;
  logic         prefix;

  fetch_entry_t q_head;
  fetch_entry_t q_in;
  logic [1:0]   q_count;
  logic         q_full;
  logic         q_empty;

  logic         issue;
  logic         req_open;
  logic         push;
  logic         pop;

  // New requests only from FETCH with room in the queue; an already-issued
  // request (pend) stays on the bus until acked, even across halt or redirect.
  assign issue    = (state_q == FETCH) && !q_full && !discard;
  assign mem_req  = rst_n & (pend | issue);
  assign mem_addr = discard ? disc_addr : fpc;
  assign req_open = mem_req & !mem_ack;
  assign push     = mem_req & mem_ack & !discard & !i_redirect;
  assign pop      = o_valid & i_ready;
  assign q_in     = '{instr: mem_rdata, pc: fpc};

  assign o_valid      = !q_empty;
  assign o_instr      = o_valid ? q_head.instr : '0;
  assign o_pc         = o_valid ? q_head.pc : '0;
  assign o_is_instr16 = prefix & o_valid;

  fetch_queue u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (q_in),
    .pop       (pop),
    .flush     (i_redirect),
    .head      (q_head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  // State register for the fetch/halt FSM.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // Next-state: wake takes priority over a simultaneous halt.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   if (i_halt && !i_wake) state_d = HALTED;
      HALTED:  if (i_wake) state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // Fetch PC, outstanding/discard tracking and CB prefix flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fpc     <= RESET_PC;
      pend    <= 1'b0;
      discard <= 1'b0;
      prefix  <= 1'b0;
    end else begin
      pend <= req_open;
      if (i_redirect) begin
        fpc     <= i_redirect_pc;
        discard <= req_open;
        prefix  <= 1'b0;
      end else begin
        if (push) fpc <= fpc + 16'd1;
        if (discard && mem_ack) discard <= 1'b0;
        if (pop && i_opcode) prefix <= (q_head.instr == OP_INSTR_16) && !prefix;
      end
    end
  end

  // Address of the stale request that stays on the bus after a redirect.
  always_ff @(posedge clk) begin
    if (i_redirect && req_open && !discard) disc_addr <= fpc;
  end

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: table vectors, directed corner sequences
// and randomized traffic against a queue-based reference model.
module tb_fetch;
  import sm83_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req, mem_ack;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        o_valid, i_ready, i_opcode, o_is_instr16;
  instr_t      o_instr;
  logic [15:0] o_pc, i_redirect_pc;
  logic        i_redirect, i_halt, i_wake;

  logic        mem_req_w, o_valid_w, o_is_instr16_w;
  logic [15:0] mem_addr_w, o_pc_w;
  instr_t      o_instr_w;

  always #5 clk = ~clk;

  fetch dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .o_valid(o_valid), .i_ready(i_ready),
    .i_opcode(i_opcode), .o_instr(o_instr), .o_pc(o_pc), .o_is_instr16(o_is_instr16),
    .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc), .i_halt(i_halt), .i_wake(i_wake)
  );

  fetch #(.RESET_PC(16'hFFFF)) dut_w (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req_w), .mem_addr(mem_addr_w),
    .mem_ack(1'b1), .mem_rdata(8'h00), .o_valid(o_valid_w), .i_ready(1'b1),
    .i_opcode(1'b1), .o_instr(o_instr_w), .o_pc(o_pc_w), .o_is_instr16(o_is_instr16_w),
    .i_redirect(1'b0), .i_redirect_pc(16'h0000), .i_halt(1'b0), .i_wake(1'b0)
  );

  int n_cmp = 0;
  int n_fail = 0;

  logic [7:0] mem_img [65536];

  typedef struct { logic [7:0] b; logic [15:0] pc; } ment_t;
  ment_t       mq[$];
  logic [15:0] m_fpc, m_daddr;
  logic        m_pend, m_disc, m_prefix, m_halted;

  logic        e_req, e_valid, e_i16;
  logic [15:0] e_addr, e_pc;
  logic [7:0]  e_instr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_fpc = 16'h0000; m_daddr = 16'h0000;
    m_pend = 0; m_disc = 0; m_prefix = 0; m_halted = 0;
  endtask

  // One clock cycle: predict outputs, drive inputs, compare, advance the model.
  task automatic step(input logic ack, input logic ready, input logic op, input logic redir,
                      input logic [15:0] rpc, input logic halt, input logic wake);
    logic open_q, acked, pop;
    @(negedge clk);
    e_req   = m_pend || (!m_halted && mq.size() < 2 && !m_disc);
    e_addr  = m_disc ? m_daddr : m_fpc;
    e_valid = mq.size() > 0;
    e_instr = e_valid ? mq[0].b : 8'h00;
    e_pc    = e_valid ? mq[0].pc : 16'h0000;
    e_i16   = m_prefix && e_valid;
    mem_ack = ack && e_req;
    mem_rdata = mem_img[e_addr];
    i_ready = ready; i_opcode = op; i_redirect = redir; i_redirect_pc = rpc;
    i_halt = halt; i_wake = wake;
    #1;
    chk("mem_req", {31'b0, mem_req}, {31'b0, e_req});
    if (e_req) chk("mem_addr", {16'b0, mem_addr}, {16'b0, e_addr});
    chk("o_valid", {31'b0, o_valid}, {31'b0, e_valid});
    chk("o_instr", {24'b0, o_instr}, {24'b0, e_instr});
    chk("o_pc", {16'b0, o_pc}, {16'b0, e_pc});
    chk("o_is_instr16", {31'b0, o_is_instr16}, {31'b0, e_i16});
    acked  = ack && e_req;
    open_q = e_req && !ack;
    pop    = e_valid && ready;
    if (redir) begin
      if (open_q && !m_disc) m_daddr = m_fpc;
      m_disc = open_q;
      mq.delete();
      m_prefix = 0;
      m_fpc = rpc;
    end else begin
      if (pop) begin
        if (op) m_prefix = (mq[0].b == 8'hCB) && !m_prefix;
        void'(mq.pop_front());
      end
      if (acked) begin
        if (m_disc) m_disc = 0;
        else begin
          mq.push_back('{mem_img[e_addr], m_fpc});
          m_fpc = m_fpc + 16'd1;
        end
      end
    end
    m_pend = open_q;
    if (wake) m_halted = 0;
    else if (halt) m_halted = 1;
  endtask

  typedef struct { logic ready; logic req; logic [15:0] addr; logic valid; logic [15:0] pc; } vec_t;
  vec_t tbl[10];

  initial begin
    logic [15:0] old_addr, hold_pc;
    logic        op;

    for (int i = 0; i < 65536; i++)
      mem_img[i] = ($urandom_range(0, 3) == 0) ? 8'hCB : 8'($urandom);
    for (int i = 0; i < 16; i++) mem_img[i] = 8'h00;
    mem_img[16'h0200] = 8'hCB; mem_img[16'h0201] = 8'h37;
    mem_img[16'h0202] = 8'h00; mem_img[16'h0203] = 8'h00;
    mem_img[16'h0300] = 8'h3E; mem_img[16'h0301] = 8'hCB;
    mem_img[16'h0302] = 8'h00; mem_img[16'h0303] = 8'h00;
    mem_img[16'h0304] = 8'h00;

    // ack tied high from reset; i_ready pattern exercises backpressure.
    tbl[0] = '{0, 1, 16'h0000, 0, 16'h0000};
    tbl[1] = '{0, 1, 16'h0001, 1, 16'h0000};
    tbl[2] = '{0, 0, 16'h0002, 1, 16'h0000};
    tbl[3] = '{0, 0, 16'h0002, 1, 16'h0000};
    tbl[4] = '{1, 0, 16'h0002, 1, 16'h0000};
    tbl[5] = '{1, 1, 16'h0002, 1, 16'h0001};
    tbl[6] = '{1, 1, 16'h0003, 1, 16'h0002};
    tbl[7] = '{0, 1, 16'h0004, 1, 16'h0003};
    tbl[8] = '{1, 0, 16'h0005, 1, 16'h0003};
    tbl[9] = '{1, 1, 16'h0005, 1, 16'h0004};

    rst_n = 0; mem_ack = 0; mem_rdata = 0; i_ready = 0; i_opcode = 0;
    i_redirect = 0; i_redirect_pc = 0; i_halt = 0; i_wake = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_o_valid", {31'b0, o_valid}, 32'd0);
    chk("rst_o_instr", {24'b0, o_instr}, 32'd0);
    chk("rst_o_pc", {16'b0, o_pc}, 32'd0);
    chk("rst_o_is_instr16", {31'b0, o_is_instr16}, 32'd0);
    chk("rst_w_mem_req", {31'b0, mem_req_w}, 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1;

    // Table vectors straight out of reset.
    for (int i = 0; i < 10; i++) begin
      step(1, tbl[i].ready, 1, 0, 16'h0, 0, 0);
      chk($sformatf("tbl%0d_req", i), {31'b0, mem_req}, {31'b0, tbl[i].req});
      if (tbl[i].req) chk($sformatf("tbl%0d_addr", i), {16'b0, mem_addr}, {16'b0, tbl[i].addr});
      chk($sformatf("tbl%0d_valid", i), {31'b0, o_valid}, {31'b0, tbl[i].valid});
      chk($sformatf("tbl%0d_pc", i), {16'b0, o_pc}, {16'b0, tbl[i].pc});
      if (i == 0) chk("wrap_addr0", {16'b0, mem_addr_w}, 32'h0000FFFF);
      if (i == 1) chk("wrap_addr1", {16'b0, mem_addr_w}, 32'h00000000);
      if (i == 1) chk("wrap_pc1", {16'b0, o_pc_w}, 32'h0000FFFF);
      if (i == 2) chk("wrap_pc2", {16'b0, o_pc_w}, 32'h00000000);
    end

    // CB 37 popped as opcodes: only 0x37 is flagged as a 16-bit instruction byte.
    step(1, 1, 1, 1, 16'h0200, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step(1, 1, 1, 0, 16'h0, 0, 0);
      if (o_valid && o_pc >= 16'h0200 && o_pc <= 16'h0202)
        chk("cb_pair_i16", {31'b0, o_is_instr16}, {31'b0, o_pc == 16'h0201});
    end

    // 3E CB 00 with CB consumed as an operand: flag never set.
    step(1, 1, 1, 1, 16'h0300, 0, 0);
    for (int i = 0; i < 6; i++) begin
      op = !(mq.size() > 0 && mq[0].pc == 16'h0301);
      step(1, 1, op, 0, 16'h0, 0, 0);
      if (o_valid && o_pc >= 16'h0300 && o_pc <= 16'h0302)
        chk("cb_operand_i16", {31'b0, o_is_instr16}, 32'd0);
    end

    // Redirect with a request outstanding and acked three cycles later.
    repeat (3) step(0, 1, 1, 0, 16'h0, 0, 0);
    step(0, 1, 1, 1, 16'h0150, 0, 0);
    old_addr = e_addr;
    chk("rdp_req_at_redirect", {31'b0, mem_req}, 32'd1);
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 1, 0, 16'h0, 0, 0);
      chk("rdp_hold_addr", {16'b0, mem_addr}, {16'b0, old_addr});
      chk("rdp_no_valid", {31'b0, o_valid}, 32'd0);
    end
    step(1, 1, 1, 0, 16'h0, 0, 0);
    chk("rdp_ack_addr", {16'b0, mem_addr}, {16'b0, old_addr});
    step(1, 1, 1, 0, 16'h0, 0, 0);
    chk("rdp_new_req", {31'b0, mem_req}, 32'd1);
    chk("rdp_new_addr", {16'b0, mem_addr}, 32'h00000150);
    chk("rdp_dropped", {31'b0, o_valid}, 32'd0);
    step(1, 1, 1, 0, 16'h0, 0, 0);
    chk("rdp_first_valid", {31'b0, o_valid}, 32'd1);
    chk("rdp_first_pc", {16'b0, o_pc}, 32'h00000150);

    // Halt with one byte queued, then wake.
    repeat (3) step(1, 1, 1, 0, 16'h0, 0, 0);
    step(0, 1, 1, 0, 16'h0, 1, 0);
    step(1, 0, 1, 0, 16'h0, 0, 0);
    chk("halt_outstanding_completes", {31'b0, mem_req}, 32'd1);
    hold_pc = m_fpc - 16'd1;
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1, 0, 16'h0, 0, 0);
      chk("halt_no_req", {31'b0, mem_req}, 32'd0);
      chk("halt_hold_valid", {31'b0, o_valid}, 32'd1);
      chk("halt_hold_pc", {16'b0, o_pc}, {16'b0, hold_pc});
    end
    step(1, 1, 1, 0, 16'h0, 0, 0);
    chk("halt_pop_valid", {31'b0, o_valid}, 32'd1);
    step(1, 0, 1, 0, 16'h0, 0, 0);
    chk("halt_empty", {31'b0, o_valid}, 32'd0);
    chk("halt_still_no_req", {31'b0, mem_req}, 32'd0);
    step(1, 0, 1, 0, 16'h0, 0, 1);
    step(1, 1, 1, 0, 16'h0, 0, 0);
    chk("wake_req", {31'b0, mem_req}, 32'd1);
    chk("wake_addr", {16'b0, mem_addr}, {16'b0, hold_pc + 16'd1});

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, 1'($urandom),
           $urandom_range(0, 99) < 5, 16'($urandom),
           $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 10);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch.md
# fetch

Instruction-byte fetch stage of the SM83 core, directly upstream of `decode`. It owns the fetch PC and issues single-byte reads on the memory bus. Returned bytes are buffered in a 2-entry queue and presented to decode/control with a valid/ready handshake. It also tracks the 0xCB prefix to drive decode's `i_is_instr16`, and supports redirect (jumps, calls, returns, RST), halt and wake.

## Interface
- `RESET_PC`, 16'h0000, fetch PC loaded on reset
- `clk` in 1, core clock; single clock domain
- `rst_n` in 1, reset; synchronous, active-low
- `mem_req` out 1, read request; held until `mem_ack`
- `mem_addr` out 16, read address; stable while `mem_req` high and `mem_ack` low
- `mem_ack` in 1, request accepted; `mem_rdata` valid this cycle
- `mem_rdata` in 8, read data
- `o_valid` out 1, queue head valid
- `i_ready` in 1, consumer takes the head this cycle (pop = `o_valid & i_ready`)
- `i_opcode` in 1, qualifies a pop: 1 = popped byte is an opcode, 0 = immediate operand
- `o_instr` out 8 (`instr_t`), head byte
- `o_pc` out 16, address of the head byte
- `o_is_instr16` out 1, head byte is the second byte of a CB-prefixed instruction; drives decode `i_is_instr16`
- `i_redirect` in 1, flush and restart at `i_redirect_pc`
- `i_redirect_pc` in 16, new fetch PC
- `i_halt` in 1, stop issuing fetches (CTL_HALT/CTL_STOP)
- `i_wake` in 1, resume fetching

## Operation
- **FSM states:** FETCH, HALTED. Reset enters FETCH.
  - FETCH → HALTED on `i_halt`.
  - HALTED → FETCH on `i_wake`.
  - `i_halt` and `i_wake` in the same cycle: `i_wake` wins.
- **Requests:** `mem_req = (state==FETCH) & (count<2) & !discard`, or `discard` is high and the request is still outstanding. The address is `fpc`, or the held address of the outstanding request.
- **On `mem_ack` without discard:** push {`mem_rdata`, `fpc`} and set `fpc <= fpc+1`. The increment wraps mod 2^16 (FFFF → 0000).
- **Queue:** 2 entries, first-in first-out.
  - Push and pop in the same cycle are both honoured, including when full.
  - No push occurs when full, because `mem_req` is low.
- **Prefix tracking:**
  - A pop with `i_opcode=1`, head byte 8'hCB and `o_is_instr16=0` sets the `prefix` flag.
  - Any other pop with `i_opcode=1` clears it.
  - Pops with `i_opcode=0` leave it unchanged.
  - `o_is_instr16 = prefix & o_valid`.
- **Redirect:** in the cycle of `i_redirect`:
  - Flush the queue, clear `prefix`, set `fpc <= i_redirect_pc`.
  - A pop in the same cycle is still reported to the consumer, then discarded.
  - If a request is outstanding and not acked this cycle, set `discard`. That request stays on the bus with its old address until acked, and its data is dropped.
  - An ack in the redirect cycle itself is dropped.
  - Redirect while HALTED updates `fpc` and flushes; the state stays HALTED.
- **Halt:**
  - An outstanding request completes normally.
  - Queue contents are retained.
  - No new requests are issued while HALTED.

## Timing
- **Reset values:** `mem_req`=0, `o_valid`=0, `o_is_instr16`=0, `o_instr`=0, `o_pc`=0, `fpc`=`RESET_PC`, count=0, `discard`=0, `prefix`=0, state=FETCH.
- **First request:** `mem_req` goes high in the first cycle after `rst_n` deasserts, with `mem_addr=RESET_PC`.
- **Latency:** ack in cycle N gives `o_valid` in cycle N+1.
- **Throughput:** with `mem_ack` and `i_ready` tied high, one byte per cycle, addresses increment every cycle.
- **Redirect latency:** with nothing outstanding, the first request to the new PC is issued in cycle N+1.
- **Combinational paths:** `mem_ack` → push logic only; no path from `i_ready` to `mem_req`.
- **Reset mid-operation:** all state is cleared. A pending bus request is abandoned; the bus tolerates this.

## Structure
- **Add to `sm83_pkg`:**
  - `fetch_state_t` {FETCH, HALTED}
  - `FETCH_Q_DEPTH` = 2
  - `fetch_entry_t` {`instr_t` byte, logic [15:0] pc}
- **Reuse** the existing `OP_INSTR_16` constant for prefix detection.
- **Sub-module:** `fetch_queue`, a 2-entry synchronous FIFO of `fetch_entry_t` with push, pop, flush, count, full and empty.

## Test plan
- **Reset:** release reset, memory returns 8'h00 at 0x0000–0x0003 with ack tied high → `mem_addr` 0000, 0001, 0002…; `o_valid` from the second cycle with `o_pc` 0000, 0001….
- **Backpressure:** hold `i_ready=0` → after 2 acks `mem_req`=0 with `mem_addr` at 0x0002; release `i_ready` → bytes emerge in order, none lost.
- **CB prefix:** stream CB 37, popped with `i_opcode=1` → `o_is_instr16`=1 on 0x37 only. Stream 3E CB 00 with the CB popped as `i_opcode=0` → `o_is_instr16` never set.
- **Redirect with pending request:** `mem_ack` delayed 3 cycles, `i_redirect` to 0x0150 in the first cycle → `mem_addr` stays at the old address until ack, that data is dropped, the next request is 0x0150, and the first valid `o_pc` is 0x0150.
- **Wrap:** `RESET_PC`=16'hFFFF → addresses FFFF, 0000.
- **Halt/wake:** with the queue holding one byte, `i_halt` → no `mem_req`, byte still poppable. `i_wake` → requests resume at the next `fpc`.
